// File: rtl/pmp_pkg.sv
// pmp_pkg: shared types and constants for the PMP check arbiter.
//   pmp_arb_state_t : arbiter FSM state (RUN, DRAIN, UPD, SETTLE) as 2-bit constants
//   pmp_req_id_t    : requester identity (REQ_I = fetch, REQ_D = data)
//   pmp_chk_req_t   : one check as presented to the PMP checker
package pmp_pkg;

  // Physical address MSB carried to the checker; the struct below is sized from it.
  localparam int PMP_PA_MSB = 55;

  typedef logic [1:0] pmp_arb_state_t;
  localparam pmp_arb_state_t ST_RUN    = 2'd0;
  localparam pmp_arb_state_t ST_DRAIN  = 2'd1;
  localparam pmp_arb_state_t ST_UPD    = 2'd2;
  localparam pmp_arb_state_t ST_SETTLE = 2'd3;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } pmp_req_id_t;

  // Access type used for instruction fetch checks.
  localparam logic [1:0] ACC_X = 2'b00;

  typedef struct packed {
    logic [PMP_PA_MSB:0] addr;
    logic [1:0]          acc;
    logic [1:0]          prv;
    logic                mprv;
    logic [1:0]          mpp;
  } pmp_chk_req_t;

endpackage

// File: rtl/pmp_rr_arb2.sv
// pmp_rr_arb2: two-way round-robin arbiter.
//   clk300p  in  clock
//   rst      in  synchronous reset, active-high (last_grant -> REQ_D, so I wins first)
//   req[1:0] in  requests, bit 0 = fetch (I), bit 1 = data (D)
//   en       in  grant enable; no grant and no state change when low
//   gnt[1:0] out one-hot grant (or zero)
module pmp_rr_arb2
  import pmp_pkg::*;
(
  input  logic       clk300p,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  pmp_req_id_t last_grant;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        // Conflict: the requester not served last time wins.
        gnt = (last_grant == REQ_D) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk300p) begin
    if (rst) begin
      last_grant <= REQ_D;
    end else if (gnt[0]) begin
      last_grant <= REQ_I;
    end else if (gnt[1]) begin
      last_grant <= REQ_D;
    end
  end

endmodule

// File: rtl/pmp_check_arbiter.sv
// pmp_check_arbiter: shares one single-cycle PMP checker between fetch (I) and data (D).
//   Requests (i_req_*, d_req_*) are arbitrated round-robin; the winner gets ready and is
//   driven onto pmp_* in the same cycle. The checker's pmp_ok (one cycle later) is routed
//   back as i_rsp_* / d_rsp_* to the issuing requester. cfg_upd_req/cfg_upd_ack quiesce
//   the checker around pmpcfg/pmpaddr writes (RUN -> DRAIN -> UPD -> SETTLE -> RUN).
//   mprv/mpp are forwarded for data checks only; fetch checks use acc=00, mprv=0.
// Configuration macro:
//   PMP_ARB_RSP_REG_EN  adds a register stage on rsp_valid/rsp_ok (latency 2).
module pmp_check_arbiter
  import pmp_pkg::*;
#(
  parameter int PMP_MSB     = PMP_PA_MSB,
  parameter int PMP_ENTRIES = 16
) (
  input  logic             clk300p,
  input  logic             rst,
  input  logic             i_req_valid,
  output logic             i_req_ready,
  input  logic [PMP_MSB:0] i_req_addr,
  input  logic [1:0]       i_req_prv,
  input  logic             d_req_valid,
  output logic             d_req_ready,
  input  logic [PMP_MSB:0] d_req_addr,
  input  logic [1:0]       d_req_acc,
  input  logic [1:0]       d_req_prv,
  input  logic             mprv,
  input  logic [1:0]       mpp,
  output logic             i_rsp_valid,
  output logic             i_rsp_ok,
  output logic             d_rsp_valid,
  output logic             d_rsp_ok,
  input  logic             cfg_upd_req,
  output logic             cfg_upd_ack,
  output logic             pmp_valid,
  output logic [PMP_MSB:0] pmp_address,
  output logic [1:0]       pmp_acc,
  output logic [1:0]       pmp_prv,
  output logic             pmp_mprv,
  output logic [1:0]       pmp_mpp,
  input  logic             pmp_ok
);

  // The checker request struct is sized by the package; the port width must agree.
  if (PMP_MSB != PMP_PA_MSB) begin : g_bad_msb
    $error("pmp_check_arbiter: PMP_MSB must equal pmp_pkg::PMP_PA_MSB");
  end
  // PMP_ENTRIES is carried for the checker only; reject nonsensical values early.
  if (PMP_ENTRIES < 1 || PMP_ENTRIES > 64) begin : g_bad_entries
    $error("pmp_check_arbiter: PMP_ENTRIES out of range 1..64");
  end

  pmp_arb_state_t state, state_nxt;
  logic           grant_en;
  logic [1:0]     gnt;
  logic           issue;
  pmp_chk_req_t   chk;
  logic           tag_valid;
  pmp_req_id_t    tag_owner;
  logic           in_flight;

  // Grants only in RUN, and never in the cycle an update request is seen.
  assign grant_en = !rst && (state == ST_RUN) && !cfg_upd_req;

  pmp_rr_arb2 u_arb (
    .clk300p (clk300p),
    .rst     (rst),
    .req     ({d_req_valid, i_req_valid}),
    .en      (grant_en),
    .gnt     (gnt)
  );

  assign issue       = |gnt;
  assign i_req_ready = gnt[0];
  assign d_req_ready = gnt[1];

  always_comb begin
    chk = '0;
    if (gnt[0]) begin
      chk.addr = i_req_addr;
      chk.acc  = ACC_X;
      chk.prv  = i_req_prv;
    end else if (gnt[1]) begin
      chk.addr = d_req_addr;
      chk.acc  = d_req_acc;
      chk.prv  = d_req_prv;
      chk.mprv = mprv;
      chk.mpp  = mpp;
    end
  end

  assign pmp_valid   = issue;
  assign pmp_address = chk.addr;
  assign pmp_acc     = chk.acc;
  assign pmp_prv     = chk.prv;
  assign pmp_mprv    = chk.mprv;
  assign pmp_mpp     = chk.mpp;

  // Tag of the check whose result the checker presents this cycle.
  always_ff @(posedge clk300p) begin
    if (rst) begin
      tag_valid <= 1'b0;
      tag_owner <= REQ_I;
    end else begin
      tag_valid <= issue;
      tag_owner <= gnt[1] ? REQ_D : REQ_I;
    end
  end

`ifdef PMP_ARB_RSP_REG_EN
  logic i_rsp_valid_q, i_rsp_ok_q, d_rsp_valid_q, d_rsp_ok_q;

  always_ff @(posedge clk300p) begin
    if (rst) begin
      i_rsp_valid_q <= 1'b0;
      i_rsp_ok_q    <= 1'b0;
      d_rsp_valid_q <= 1'b0;
      d_rsp_ok_q    <= 1'b0;
    end else begin
      i_rsp_valid_q <= tag_valid && (tag_owner == REQ_I);
      i_rsp_ok_q    <= tag_valid && (tag_owner == REQ_I) && pmp_ok;
      d_rsp_valid_q <= tag_valid && (tag_owner == REQ_D);
      d_rsp_ok_q    <= tag_valid && (tag_owner == REQ_D) && pmp_ok;
    end
  end

  assign in_flight   = tag_valid || i_rsp_valid_q || d_rsp_valid_q;
  assign i_rsp_valid = !rst && i_rsp_valid_q;
  assign i_rsp_ok    = !rst && i_rsp_ok_q;
  assign d_rsp_valid = !rst && d_rsp_valid_q;
  assign d_rsp_ok    = !rst && d_rsp_ok_q;
`else
  // A check in flight while reset is asserted must not surface as a response.
  assign in_flight   = tag_valid;
  assign i_rsp_valid = !rst && tag_valid && (tag_owner == REQ_I);
  assign i_rsp_ok    = i_rsp_valid && pmp_ok;
  assign d_rsp_valid = !rst && tag_valid && (tag_owner == REQ_D);
  assign d_rsp_ok    = d_rsp_valid && pmp_ok;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (cfg_upd_req) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (!in_flight) state_nxt = ST_UPD;
      ST_UPD:    if (!cfg_upd_req) state_nxt = ST_SETTLE;
      ST_SETTLE: state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk300p) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  assign cfg_upd_ack = !rst && (state == ST_UPD);

endmodule

// File: tb/tb_pmp_check_arbiter.sv
// Bench for pmp_check_arbiter: directed scenarios followed by a randomized run. In the
// randomized run a monitor predicts grants from the round-robin rule, pushes expected
// responses (owner, due cycle, ok) at issue and pops them when the DUT responds.
module tb_pmp_check_arbiter;

`ifdef PMP_ARB_RSP_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk300p = 1'b0;
  logic        rst;
  logic        i_req_valid, i_req_ready;
  logic [55:0] i_req_addr;
  logic [1:0]  i_req_prv;
  logic        d_req_valid, d_req_ready;
  logic [55:0] d_req_addr;
  logic [1:0]  d_req_acc, d_req_prv;
  logic        mprv;
  logic [1:0]  mpp;
  logic        i_rsp_valid, i_rsp_ok, d_rsp_valid, d_rsp_ok;
  logic        cfg_upd_req, cfg_upd_ack;
  logic        pmp_valid;
  logic [55:0] pmp_address;
  logic [1:0]  pmp_acc, pmp_prv, pmp_mpp;
  logic        pmp_mprv;
  logic        pmp_ok = 1'b0;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  bit mon_en  = 0;   // randomized-phase scoreboard active
  bit rand_ok = 0;   // checker model returns random results
  bit ok_cfg  = 0;   // checker result used by directed scenarios
  bit ok_next = 0;
  bit ok_now;
  bit i_acc   = 0;
  bit d_acc   = 0;
  bit last_d  = 1;   // reference: last grant went to D
  logic [1:0] exp_gnt;

  typedef struct {
    int due;
    bit ok;
  } exp_t;
  exp_t iq[$];
  exp_t dq[$];

  always #5 clk300p = ~clk300p;

  pmp_check_arbiter dut (
    .clk300p     (clk300p),
    .rst         (rst),
    .i_req_valid (i_req_valid),
    .i_req_ready (i_req_ready),
    .i_req_addr  (i_req_addr),
    .i_req_prv   (i_req_prv),
    .d_req_valid (d_req_valid),
    .d_req_ready (d_req_ready),
    .d_req_addr  (d_req_addr),
    .d_req_acc   (d_req_acc),
    .d_req_prv   (d_req_prv),
    .mprv        (mprv),
    .mpp         (mpp),
    .i_rsp_valid (i_rsp_valid),
    .i_rsp_ok    (i_rsp_ok),
    .d_rsp_valid (d_rsp_valid),
    .d_rsp_ok    (d_rsp_ok),
    .cfg_upd_req (cfg_upd_req),
    .cfg_upd_ack (cfg_upd_ack),
    .pmp_valid   (pmp_valid),
    .pmp_address (pmp_address),
    .pmp_acc     (pmp_acc),
    .pmp_prv     (pmp_prv),
    .pmp_mprv    (pmp_mprv),
    .pmp_mpp     (pmp_mpp),
    .pmp_ok      (pmp_ok)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk300p);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    cfg_upd_req = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  always @(posedge clk300p) cyc <= cyc + 1;

  // Checker model: result of a check issued in cycle n is presented in cycle n+1.
  always @(posedge clk300p) begin
    #1;
    pmp_ok = ok_next;
  end

  always @(negedge clk300p) begin
    ok_now = rand_ok ? 1'($urandom) : ok_cfg;
    if (mon_en) begin
      if (iq.size() > 0 && iq[0].due == cyc) begin
        chk("i_rsp", 64'({i_rsp_valid, i_rsp_ok}), 64'({1'b1, iq[0].ok}));
        void'(iq.pop_front());
      end else begin
        chk("i_rsp_idle", 64'({i_rsp_valid, i_rsp_ok}), 64'(0));
      end
      if (dq.size() > 0 && dq[0].due == cyc) begin
        chk("d_rsp", 64'({d_rsp_valid, d_rsp_ok}), 64'({1'b1, dq[0].ok}));
        void'(dq.pop_front());
      end else begin
        chk("d_rsp_idle", 64'({d_rsp_valid, d_rsp_ok}), 64'(0));
      end
      if (i_req_valid && d_req_valid) exp_gnt = last_d ? 2'b01 : 2'b10;
      else exp_gnt = {d_req_valid, i_req_valid};
      chk("gnt", 64'({d_req_ready, i_req_ready}), 64'(exp_gnt));
      if (exp_gnt[0]) begin
        chk("issue_i", 64'({pmp_valid, pmp_address, pmp_acc, pmp_prv, pmp_mprv}),
            64'({1'b1, i_req_addr, 2'b00, i_req_prv, 1'b0}));
        iq.push_back('{due: cyc + LAT, ok: ok_now});
        last_d = 0;
      end else if (exp_gnt[1]) begin
        chk("issue_d", {pmp_valid, pmp_address, pmp_acc, pmp_prv, pmp_mprv, pmp_mpp},
            {1'b1, d_req_addr, d_req_acc, d_req_prv, mprv, mpp});
        dq.push_back('{due: cyc + LAT, ok: ok_now});
        last_d = 1;
      end else begin
        chk("no_issue", 64'(pmp_valid), 64'(0));
      end
      i_acc = i_req_valid && i_req_ready;
      d_acc = d_req_valid && d_req_ready;
    end
    ok_next = pmp_valid ? ok_now : 1'($urandom);
  end

  initial begin
    int j;
    rst = 1'b1;
    i_req_valid = 0; i_req_addr = '0; i_req_prv = 0;
    d_req_valid = 0; d_req_addr = '0; d_req_acc = 0; d_req_prv = 0;
    mprv = 0; mpp = 0; cfg_upd_req = 0;
    tick();
    tick();

    // Reset: every output low even with requests pending.
    i_req_valid = 1; d_req_valid = 1;
    @(negedge clk300p);
    chk("rst_ctl", 64'({i_req_ready, d_req_ready, i_rsp_valid, i_rsp_ok, d_rsp_valid, d_rsp_ok,
                        cfg_upd_ack, pmp_valid}), 64'(0));
    chk("rst_pmp", 64'({pmp_address, pmp_acc, pmp_prv, pmp_mprv, pmp_mpp}), 64'(0));
    tick();
    rst = 0;

    // 1: fetch only; MPRV must not reach a fetch check.
    d_req_valid = 0;
    i_req_valid = 1; i_req_addr = 56'h1000; i_req_prv = 2'b00; mprv = 1; mpp = 2'b11;
    ok_cfg = 1;
    @(negedge clk300p);
    chk("t1_ready", 64'({i_req_ready, d_req_ready}), 64'(2'b10));
    chk("t1_pmp", 64'({pmp_valid, pmp_address, pmp_acc, pmp_prv, pmp_mprv}),
        64'({1'b1, 56'h1000, 2'b00, 2'b00, 1'b0}));
    tick();
    i_req_valid = 0; mprv = 0; mpp = 0;
    repeat (LAT - 1) tick();
    @(negedge clk300p);
    chk("t1_rsp", 64'({i_rsp_valid, i_rsp_ok, d_rsp_valid, d_rsp_ok}), 64'(4'b1100));
    tick();

    // 2: both valid from reset -> I,D,I,D.
    do_reset();
    i_req_valid = 1; i_req_addr = 56'h2000;
    d_req_valid = 1; d_req_addr = 56'h3000; d_req_acc = 2'b01;
    for (int k = 0; k < 4 + LAT; k++) begin
      @(negedge clk300p);
      if (k < 4) chk("t2_gnt", 64'({d_req_ready, i_req_ready}), (k % 2 == 0) ? 64'd1 : 64'd2);
      j = k - LAT;
      chk("t2_rsp", 64'({d_rsp_valid, i_rsp_valid}),
          (j >= 0 && j < 4) ? ((j % 2 == 0) ? 64'd1 : 64'd2) : 64'd0);
      tick();
      if (k == 3) begin
        i_req_valid = 0;
        d_req_valid = 0;
      end
    end

    // 3: data write with MPRV=1, MPP=S, denied.
    d_req_valid = 1; d_req_addr = 56'h4000; d_req_acc = 2'b11; d_req_prv = 2'b00;
    mprv = 1; mpp = 2'b01; ok_cfg = 0;
    @(negedge clk300p);
    chk("t3_ready", 64'({d_req_ready, i_req_ready}), 64'(2'b10));
    chk("t3_pmp", 64'({pmp_valid, pmp_acc, pmp_prv, pmp_mprv, pmp_mpp}),
        64'({1'b1, 2'b11, 2'b00, 1'b1, 2'b01}));
    tick();
    d_req_valid = 0; mprv = 0; mpp = 0;
    repeat (LAT - 1) tick();
    @(negedge clk300p);
    chk("t3_rsp", 64'({d_rsp_valid, d_rsp_ok, i_rsp_valid}), 64'(3'b100));
    tick();

    // 4: update request the cycle after a D grant.
    d_req_valid = 1; d_req_addr = 56'h5000; d_req_acc = 2'b01; ok_cfg = 1;
    @(negedge clk300p);
    chk("t4_grant", 64'({d_req_ready, i_req_ready}), 64'(2'b10));
    tick();
    cfg_upd_req = 1; i_req_valid = 1; i_req_addr = 56'h6000; d_req_addr = 56'h5040;
    for (int c = 1; c <= 3 + LAT; c++) begin
      @(negedge clk300p);
      chk("t4_noready", 64'({d_req_ready, i_req_ready}), 64'(0));
      chk("t4_ack", 64'(cfg_upd_ack), 64'(c >= 2 + LAT));
      chk("t4_rsp", 64'({d_rsp_valid, d_rsp_ok}), (c == LAT) ? 64'd3 : 64'd0);
      tick();
    end
    cfg_upd_req = 0;
    @(negedge clk300p);
    chk("t4_upd_last", 64'({cfg_upd_ack, d_req_ready, i_req_ready}), 64'(3'b100));
    tick();
    @(negedge clk300p);
    chk("t4_settle", 64'({cfg_upd_ack, d_req_ready, i_req_ready}), 64'(3'b000));
    tick();
    @(negedge clk300p);
    chk("t4_resume", 64'({cfg_upd_ack, d_req_ready, i_req_ready, pmp_address}),
        64'({3'b001, 56'h6000}));
    tick();
    i_req_valid = 0;
    @(negedge clk300p);
    chk("t4_resume_d", 64'({d_req_ready, pmp_address}), 64'({1'b1, 56'h5040}));
    tick();
    d_req_valid = 0;
    repeat (LAT + 1) tick();

    // 4b: request and a one-cycle update pulse rise together; update wins.
    i_req_valid = 1; i_req_addr = 56'h7000; cfg_upd_req = 1;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk300p);
      chk("t4b_ack", 64'(cfg_upd_ack), 64'(c == 2));
      chk("t4b_ready", 64'(i_req_ready), 64'(c == 4));
      tick();
      if (c == 0) cfg_upd_req = 0;
    end
    i_req_valid = 0;
    repeat (LAT + 1) tick();

    // 5: reset the cycle after an I grant.
    i_req_valid = 1; i_req_addr = 56'h8000;
    @(negedge clk300p);
    chk("t5_grant", 64'({d_req_ready, i_req_ready}), 64'(2'b01));
    tick();
    rst = 1; d_req_valid = 1;
    @(negedge clk300p);
    chk("t5_rst_ctl", 64'({i_req_ready, d_req_ready, i_rsp_valid, i_rsp_ok, d_rsp_valid,
                           d_rsp_ok, cfg_upd_ack, pmp_valid}), 64'(0));
    tick();
    rst = 0;
    @(negedge clk300p);
    chk("t5_first", 64'({d_req_ready, i_req_ready, i_rsp_valid, d_rsp_valid}), 64'(4'b0100));
    tick();

    // Randomized run against the scoreboard.
    do_reset();
    last_d = 1; rand_ok = 1; mon_en = 1;
    for (int n = 0; n < 600; n++) begin
      if (!i_req_valid || i_acc) begin
        i_req_valid = ($urandom_range(3) != 0);
        i_req_addr  = 56'({$urandom, $urandom});
        i_req_prv   = 2'($urandom);
      end
      if (!d_req_valid || d_acc) begin
        d_req_valid = ($urandom_range(3) != 0);
        d_req_addr  = 56'({$urandom, $urandom});
        d_req_acc   = $urandom_range(1) ? 2'b11 : 2'b01;
        d_req_prv   = 2'($urandom);
      end
      i_acc = 0;
      d_acc = 0;
      mprv = 1'($urandom);
      mpp  = 2'($urandom);
      tick();
    end
    i_req_valid = 0;
    d_req_valid = 0;
    repeat (LAT + 2) tick();
    mon_en = 0;
    chk("i_queue_drained", 64'(iq.size()), 64'(0));
    chk("d_queue_drained", 64'(dq.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
